// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: round-robin arbiter sharing one single-port line memory
// between the I-cache and D-cache miss ports. One transfer in flight at a time;
// pulsed strobes are held in pending flags so none are lost.
// Optional feature: define ARB_TIMEOUT_EN to build the BUSY watchdog.
module mem_line_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_strobe,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic [LINE_WIDTH-1:0] ic_rdata,
    output logic                  ic_done,
    input  logic                  dc_strobe,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic                  dc_rw,
    input  logic [LINE_WIDTH-1:0] dc_wdata,
    output logic [LINE_WIDTH-1:0] dc_rdata,
    output logic                  dc_done,
    output logic                  mem_strobe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rw,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_done,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                state_q;
    logic                  last_dc_q;   // 1: D-cache was granted most recently
    logic                  grant_dc_q;  // owner of the in-flight transfer
    logic                  ic_pend_q;
    logic                  dc_pend_q;

    logic                  ic_req;
    logic                  dc_req;
    logic                  pick_dc;
    logic                  grant_now;
    logic                  ic_grant;
    logic                  dc_grant;
    logic                  finish;
    logic                  tmo_fire;
    logic [LINE_WIDTH-1:0] resp_data;

    // Request view, round-robin pick and completion decode
    always_comb begin
        ic_req    = ic_strobe | ic_pend_q;
        dc_req    = dc_strobe | dc_pend_q;
        // On a tie the requester that was not served last wins
        pick_dc   = dc_req & (~ic_req | ~last_dc_q);
        grant_now = (state_q == StIdle) & (ic_req | dc_req);
        ic_grant  = grant_now & ~pick_dc;
        dc_grant  = grant_now & pick_dc;
        // mem_done wins over a simultaneous timeout
        finish    = (state_q == StBusy) & (mem_done | tmo_fire);
        resp_data = mem_done ? mem_rdata : '0;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q;
    logic            tmo_err_q;

    // Fires on the edge closing the TIMEOUT_CYCLES-th BUSY cycle
    assign tmo_fire    = (state_q == StBusy) & ~mem_done &
                         (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_err_q;

    // Watchdog counter, held at zero while idle; sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == StBusy) ? tmo_cnt_q + 1'b1 : '0;
            tmo_err_q <= tmo_err_q | tmo_fire;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM with registered memory-side and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_dc_q  <= 1'b1;
            grant_dc_q <= 1'b0;
            ic_pend_q  <= 1'b0;
            dc_pend_q  <= 1'b0;
            mem_strobe <= 1'b0;
            mem_addr   <= '0;
            mem_rw     <= 1'b0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            ic_done    <= 1'b0;
            dc_done    <= 1'b0;
            ic_rdata   <= '0;
            dc_rdata   <= '0;
        end else begin
            mem_strobe <= 1'b0;
            ic_done    <= 1'b0;
            dc_done    <= 1'b0;
            // A granted strobe is consumed; one on top of a pending flag is a new request
            ic_pend_q  <= ic_grant ? (ic_strobe & ic_pend_q) : (ic_pend_q | ic_strobe);
            dc_pend_q  <= dc_grant ? (dc_strobe & dc_pend_q) : (dc_pend_q | dc_strobe);
            case (state_q)
                StIdle: begin
                    if (grant_now) begin
                        state_q    <= StBusy;
                        busy       <= 1'b1;
                        mem_strobe <= 1'b1;
                        grant_dc_q <= pick_dc;
                        last_dc_q  <= pick_dc;
                        if (pick_dc) begin
                            mem_addr  <= dc_addr;
                            mem_rw    <= dc_rw;
                            mem_wdata <= dc_wdata;
                        end else begin
                            mem_addr  <= ic_addr;
                            mem_rw    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                StBusy: begin
                    if (finish) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        if (grant_dc_q) begin
                            dc_done  <= 1'b1;
                            dc_rdata <= resp_data;
                        end else begin
                            ic_done  <= 1'b1;
                            ic_rdata <= resp_data;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed self-checking bench for mem_line_arbiter with a small latency-driven
// line-memory model. The timeout scenario builds only with ARB_TIMEOUT_EN.
module tb_mem_line_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_strobe = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic [LW-1:0] ic_rdata;
    logic          ic_done;
    logic          dc_strobe = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic          dc_rw = 1'b0;
    logic [LW-1:0] dc_wdata = '0;
    logic [LW-1:0] dc_rdata;
    logic          dc_done;
    logic          mem_strobe;
    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic          busy;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_line_arbiter #(
        .ADDR_WIDTH    (AW),
        .LINE_WIDTH    (LW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ic_strobe  (ic_strobe),
        .ic_addr    (ic_addr),
        .ic_rdata   (ic_rdata),
        .ic_done    (ic_done),
        .dc_strobe  (dc_strobe),
        .dc_addr    (dc_addr),
        .dc_rw      (dc_rw),
        .dc_wdata   (dc_wdata),
        .dc_rdata   (dc_rdata),
        .dc_done    (dc_done),
        .mem_strobe (mem_strobe),
        .mem_addr   (mem_addr),
        .mem_rw     (mem_rw),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Memory model: answers mem_lat cycles after a strobe; data is the fixed
    // pattern when use_fixed is set, otherwise the request address replicated.
    bit            mem_en    = 1'b1;
    int            mem_lat   = 3;
    bit            use_fixed = 1'b0;
    logic [LW-1:0] fixed_data = '0;
    int            mem_cnt   = 0;
    logic [AW-1:0] req_addr  = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt  = 0;
            mem_done = 1'b0;
        end else begin
            mem_done = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = use_fixed ? fixed_data : {8{req_addr}};
                end
            end
            if (mem_strobe && mem_en) begin
                req_addr = mem_addr;
                mem_cnt  = mem_lat;
            end
        end
    end

    // Monitors: done-pulse counts and the order of issued addresses
    int            ic_done_cnt = 0;
    int            dc_done_cnt = 0;
    logic [AW-1:0] order_q[$];

    always @(negedge clk) begin
        if (ic_done) ic_done_cnt++;
        if (dc_done) dc_done_cnt++;
        if (mem_strobe) order_q.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for the selected done pulse, bounded; n counts negedges waited
    task automatic wait_done(input string tag, input bit dc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dc ? dc_done : ic_done) && n < 200);
        check(tag, dc ? dc_done : ic_done, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_mem_strobe"}, mem_strobe, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_mem_rw"}, mem_rw, 1'b0);
        check({tag, "_mem_wdata"}, mem_wdata, '0);
        check({tag, "_ic_done"}, ic_done, 1'b0);
        check({tag, "_dc_done"}, dc_done, 1'b0);
        check({tag, "_ic_rdata"}, ic_rdata, '0);
        check({tag, "_dc_rdata"}, dc_rdata, '0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb watchdog");
    end

    initial begin
        int n;
        int ic0, dc0;
        logic [LW-1:0] pat;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single I-cache read, memory latency 3, fixed A5 pattern
        use_fixed  = 1'b1;
        fixed_data = {32{8'hA5}};
        ic0 = ic_done_cnt; dc0 = dc_done_cnt;
        ic_addr = 32'h0000_1000; ic_strobe = 1'b1;
        @(negedge clk);
        ic_strobe = 1'b0;
        check("ic_rd_mem_strobe", mem_strobe, 1'b1);
        check("ic_rd_busy", busy, 1'b1);
        check("ic_rd_mem_addr", mem_addr, 32'h0000_1000);
        check("ic_rd_mem_rw", mem_rw, 1'b0);
        wait_done("ic_rd_done", 1'b0, n);
        check("ic_rd_latency", n, 4);
        check("ic_rd_rdata", ic_rdata, {32{8'hA5}});
        check("ic_rd_busy_low", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("ic_rd_one_done", ic_done_cnt - ic0, 1);
        check("ic_rd_no_dc_done", dc_done_cnt - dc0, 0);
        check("ic_rdata_hold", ic_rdata, {32{8'hA5}});
        use_fixed = 1'b0;

        // D-cache write
        dc0 = dc_done_cnt;
        pat = {4{64'h0123_4567_89AB_CDEF}};
        dc_addr = 32'h0000_2040; dc_rw = 1'b1; dc_wdata = pat; dc_strobe = 1'b1;
        @(negedge clk);
        dc_strobe = 1'b0;
        check("dc_wr_mem_strobe", mem_strobe, 1'b1);
        check("dc_wr_mem_addr", mem_addr, 32'h0000_2040);
        check("dc_wr_mem_rw", mem_rw, 1'b1);
        check("dc_wr_mem_wdata", mem_wdata, pat);
        @(negedge clk);
        check("dc_wr_strobe_pulse", mem_strobe, 1'b0);
        wait_done("dc_wr_done", 1'b1, n);
        repeat (3) @(negedge clk);
        check("dc_wr_one_done", dc_done_cnt - dc0, 1);

        // Simultaneous pairs after reset: expect I, D, I, D
        do_reset();
        order_q.delete();
        dc_rw = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ic_addr = 32'h0000_4000; dc_addr = 32'h0000_5000;
            ic_strobe = 1'b1; dc_strobe = 1'b1;
            @(negedge clk);
            ic_strobe = 1'b0; dc_strobe = 1'b0;
            wait_done("pair_dc_done", 1'b1, n);
            repeat (2) @(negedge clk);
        end
        check("pair_count", order_q.size(), 4);
        if (order_q.size() == 4) begin
            check("pair_order0", order_q[0], 32'h0000_4000);
            check("pair_order1", order_q[1], 32'h0000_5000);
            check("pair_order2", order_q[2], 32'h0000_4000);
            check("pair_order3", order_q[3], 32'h0000_5000);
        end
        check("pair_ic_rdata", ic_rdata, {8{32'h0000_4000}});
        check("pair_dc_rdata", dc_rdata, {8{32'h0000_5000}});

        // D-cache pulse while an I-cache transfer is busy
        ic_addr = 32'h0000_1100; ic_strobe = 1'b1;
        @(negedge clk);
        ic_strobe = 1'b0;
        @(negedge clk);
        dc_addr = 32'h0000_3000; dc_strobe = 1'b1;
        @(negedge clk);
        dc_strobe = 1'b0;
        wait_done("pend_ic_done", 1'b0, n);
        check("pend_ic_rdata", ic_rdata, {8{32'h0000_1100}});
        @(negedge clk);
        check("pend_dc_issue", mem_strobe, 1'b1);
        check("pend_dc_addr", mem_addr, 32'h0000_3000);
        wait_done("pend_dc_done", 1'b1, n);
        check("pend_dc_rdata", dc_rdata, {8{32'h0000_3000}});
        repeat (2) @(negedge clk);

        // Reset asserted mid-transfer
        ic0 = ic_done_cnt; dc0 = dc_done_cnt;
        ic_addr = 32'h0000_6000; ic_strobe = 1'b1;
        @(negedge clk);
        ic_strobe = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_ic_done", ic_done_cnt - ic0, 0);
        check("midrst_no_dc_done", dc_done_cnt - dc0, 0);
        ic_addr = 32'h0000_7000; ic_strobe = 1'b1;
        @(negedge clk);
        ic_strobe = 1'b0;
        wait_done("midrst_clean_done", 1'b0, n);
        check("midrst_clean_rdata", ic_rdata, {8{32'h0000_7000}});
        repeat (2) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: 16 BUSY cycles then a zero-data done
        mem_en = 1'b0;
        dc_addr = 32'h0000_8000; dc_rw = 1'b0; dc_strobe = 1'b1;
        @(negedge clk);
        dc_strobe = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_busy_cycles", n, 16);
        check("tmo_dc_done", dc_done, 1'b1);
        check("tmo_dc_rdata", dc_rdata, '0);
        check("tmo_err_set", timeout_err, 1'b1);
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", timeout_err, 1'b1);
        mem_en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
